// File: rtl/axis_csum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_csum_pkg
// Description : Shared constants and state encoding for the AXI-Stream
//               checksum-append block.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_csum_pkg;

    // Width of one stream beat
    localparam int c_BYTE_W = 8;

    // Framer states: forward payload bytes, then emit one checksum byte
    typedef enum logic [0:0] {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_t;

endpackage : axis_csum_pkg
`default_nettype wire

// File: rtl/axis_csum_append_csum_acc.sv
`default_nettype none
// ============================================================================
// Module      : csum_acc
// Description : Modulo-256 byte-sum accumulator with add-enable and
//               clear-to-seed. The result is optionally inverted (one's
//               complement) when AXIS_CSUM_INVERT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
import axis_csum_pkg::*;

module csum_acc #(
    parameter logic [c_BYTE_W-1:0] CSUM_INIT = 8'h00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_add_en,
    input  logic [c_BYTE_W-1:0] i_add_data,
    input  logic                i_clr,
    output logic [c_BYTE_W-1:0] o_result
);

    logic [c_BYTE_W-1:0] r_sum;

    // Running sum; clear takes priority, carries drop off the top
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum <= CSUM_INIT;
        end else if (i_clr) begin
            r_sum <= CSUM_INIT;
        end else if (i_add_en) begin
            r_sum <= r_sum + i_add_data;
        end
    end

`ifdef AXIS_CSUM_INVERT_EN
    // Appended byte is the one's complement of the sum
    assign o_result = ~r_sum;
`else
    // Appended byte is the plain sum
    assign o_result = r_sum;
`endif

endmodule : csum_acc
`default_nettype wire

// File: rtl/axis_csum_append.sv
`default_nettype none
// ============================================================================
// Module      : axis_csum_append
// Description : AXI-Stream byte pipe that forwards each packet with one
//               registered stage and appends a modulo-256 checksum byte
//               (carrying tlast) after the last payload byte. Counts
//               completed packets.
//               Build option: define AXIS_CSUM_INVERT_EN to append the
//               one's complement of the sum instead of the sum.
// Revision    : 1.0 - initial release
// ============================================================================
import axis_csum_pkg::*;

module axis_csum_append #(
    parameter logic [c_BYTE_W-1:0] CSUM_INIT = 8'h00,
    parameter int                  CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_BYTE_W-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    output logic [c_BYTE_W-1:0] m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [CNT_W-1:0]    pkt_count
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_out_free;
    logic                w_s_tready;
    logic                w_in_xfer;
    logic                w_app_load;
    logic [c_BYTE_W-1:0] w_csum;

    logic [c_BYTE_W-1:0] r_m_tdata;
    logic                r_m_tvalid;
    logic                r_m_tlast;
    logic [CNT_W-1:0]    r_pkt_count;

    // Checksum accumulator: adds every accepted byte, reseeds on append
    csum_acc #(
        .CSUM_INIT (CSUM_INIT)
    ) u_csum_acc (
        .clk        (clk),
        .reset      (reset),
        .i_add_en   (w_in_xfer),
        .i_add_data (s_tdata),
        .i_clr      (w_app_load),
        .o_result   (w_csum)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake decode; s_tready depends only on state,
    // the output register and m_tready, never on s_tvalid
    always_comb begin
        w_state_next = r_state;
        w_s_tready   = 1'b0;
        w_app_load   = 1'b0;
        w_out_free   = !r_m_tvalid || m_tready;
        w_in_xfer    = 1'b0;
        case (r_state)
            PASS: begin
                w_s_tready = reset && w_out_free;
                w_in_xfer  = s_tvalid && w_s_tready;
                if (w_in_xfer && s_tlast) begin
                    w_state_next = APPEND;
                end
            end
            APPEND: begin
                w_app_load = w_out_free;
                if (w_app_load) begin
                    w_state_next = PASS;
                end
            end
            default: begin
                w_state_next = PASS;
            end
        endcase
    end

    // Output register: payload byte, checksum byte, or drain on transfer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_in_xfer) begin
            r_m_tdata  <= s_tdata;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b0;
        end else if (w_app_load) begin
            r_m_tdata  <= w_csum;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b1;
        end else if (r_m_tvalid && m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // Completed-packet counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pkt_count <= '0;
        end else if (w_app_load) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    assign s_tready  = w_s_tready;
    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign pkt_count = r_pkt_count;

endmodule : axis_csum_append
`default_nettype wire

// File: doc/axis_csum_append.md
AXIS_CSUM_APPEND -- requirements
Module: axis_csum_append

Interface
REQ-001 SHALL have parameter CSUM_INIT, default 8'h00, seed value of the per-packet checksum accumulator.
REQ-002 SHALL have parameter CNT_W, default 16, width of the packet counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, with synchronous, active-low reset.
REQ-005 SHALL have port s_tdata, input, 8, upstream byte.
REQ-006 SHALL have port s_tvalid, input, 1, upstream byte valid.
REQ-007 SHALL have port s_tready, output, 1, block accepts the upstream byte.
REQ-008 SHALL have port s_tlast, input, 1, last byte of the upstream packet.
REQ-009 SHALL have port m_tdata, output, 8, downstream byte (registered).
REQ-010 SHALL have port m_tvalid, output, 1, downstream byte valid (registered).
REQ-011 SHALL have port m_tready, input, 1, downstream accepts the byte.
REQ-012 SHALL have port m_tlast, output, 1, last byte of the downstream packet (registered).
REQ-013 SHALL have port pkt_count, output, CNT_W, number of packets completed since reset.

Function
REQ-014 SHALL treat an input transfer as s_tvalid && s_tready, and an output transfer as m_tvalid && m_tready.
REQ-015 SHALL implement two states: PASS and APPEND.
REQ-016 SHALL drive s_tready = (state == PASS) && (!m_tvalid || m_tready) combinationally; no combinational path from s_tvalid to s_tready.
REQ-017 PASS, on an input transfer, SHALL load the accepted byte into m_tdata with m_tvalid=1 and m_tlast=0 on the next edge, giving 1-cycle latency; s_tlast is never forwarded.
REQ-018 PASS, on an input transfer, SHALL update sum <= sum + s_tdata modulo 256, with carries discarded.
REQ-019 PASS, on an input transfer with s_tlast=1, SHALL move the state to APPEND.
REQ-020 APPEND SHALL hold s_tready=0; when !m_tvalid || m_tready, it SHALL load the checksum byte with m_tvalid=1 and m_tlast=1.
REQ-021 On that same APPEND load, the block SHALL set sum <= CSUM_INIT, set pkt_count <= pkt_count + 1, and return to PASS.
REQ-022 A packet of N input bytes SHALL produce N+1 output beats; a 1-byte packet yields the byte then the checksum.
REQ-023 SHALL clear m_tvalid on an output transfer when nothing new is loaded in the same cycle.
REQ-024 SHALL keep m_tdata, m_tvalid and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-025 Under sustained m_tready=1 and s_tvalid=1, SHALL sustain 1 byte/cycle, except for a single input bubble per packet during APPEND.
REQ-026 pkt_count SHALL wrap from all-ones to 0 without saturation.
REQ-027 SHALL ignore s_tdata and s_tlast whenever s_tready=0.

Reset
REQ-028 While reset=0 at a clock edge, SHALL set state=PASS, sum=CSUM_INIT, pkt_count=0, m_tdata=8'h00, m_tvalid=0 and m_tlast=0.
REQ-029 While reset=0, SHALL drive s_tready=0.
REQ-030 Reset asserted mid-packet or in APPEND SHALL discard the partial packet with no checksum emitted.
REQ-031 The first cycle after reset release SHALL be able to accept a byte.

Configuration
REQ-032 With AXIS_CSUM_INVERT_EN defined, the appended byte SHALL be ~sum (one's complement).
REQ-033 With AXIS_CSUM_INVERT_EN undefined, the appended byte SHALL be sum unmodified.
REQ-034 No other behaviour SHALL change with AXIS_CSUM_INVERT_EN.

Structure
REQ-035 Package axis_csum_pkg SHALL hold the byte width constant (8) and the state enum (PASS, APPEND).
REQ-036 Sub-module csum_acc SHALL hold the sum register, with add-enable, clear-to-CSUM_INIT, and a result output including the optional inversion.
REQ-037 The top level SHALL hold the FSM, handshake and output register.

Verification
REQ-038 With CSUM_INIT=0, m_tready=1 and no macro, input 01,02,03 (tlast on 03) -> output 01,02,03,06 with tlast only on 06; pkt_count=1.
REQ-039 With AXIS_CSUM_INVERT_EN defined, the same packet -> output 01,02,03,F9.
REQ-040 Input FF,FF,03 (tlast) -> checksum 01 (wrap-around); a single-byte packet 5A (tlast) -> output 5A,5A(tlast).
REQ-041 m_tready=0 for 5 cycles mid-packet -> output held stable, s_tready=0 after one buffered byte, no loss or duplication once released.
REQ-042 Back-to-back packets A0 (tlast), 10,20 (tlast) with s_tvalid held high -> output A0,A0,10,20,30; s_tready=0 in each APPEND cycle.
REQ-043 reset=0 after the 2nd byte of a packet, then a new packet 07 (tlast) -> output 07,07; pkt_count restarts at 1.
